level_counter: RTL
==================

LEVEL_COUNTER -- requirements
Module: level_counter

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning consecutive stable cycles required to accept a button level change (legal range 1..2^20-1).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port btn_up  input  1  raw asynchronous push-button, 1 = pressed, requests increment.
REQ-005 SHALL have port btn_down  input  1  raw asynchronous push-button, 1 = pressed, requests decrement.
REQ-006 SHALL have port counter_out  output  5  registered level 0..16, feeds the 16-LED thermometer display.
REQ-007 SHALL have port at_max  output  1  registered, 1 when counter_out == 16.
REQ-008 SHALL have port at_min  output  1  registered, 1 when counter_out == 0.

Function
REQ-009 SHALL pass each button through a 2-flop synchronizer before any other logic.
REQ-010 SHALL debounce each synchronized button with a 4-state FSM: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-011 STABLE_LO -> WAIT_HI when input = 1; WAIT_HI -> STABLE_HI after input held 1 for DEBOUNCE_CYCLES consecutive cycles; WAIT_HI -> STABLE_LO if input returns to 0 before that (counter cleared).
REQ-012 STABLE_HI / WAIT_LO SHALL mirror REQ-011 with opposite polarity.
REQ-013 SHALL generate a one-cycle press pulse only on the STABLE_LO -> STABLE_HI transition (via WAIT_HI); releases generate no pulse.
REQ-014 Latency: counter_out SHALL change exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples the raw button high, given the button is held throughout.
REQ-015 up pulse alone: counter_out increments by 1, saturating at 16 (no wrap to 0).
REQ-016 down pulse alone: counter_out decrements by 1, saturating at 0 (no wrap to 16/31).
REQ-017 up and down pulses in the same cycle: counter_out unchanged.
REQ-018 Holding a button SHALL produce exactly one step; no auto-repeat.
REQ-019 counter_out SHALL never take values 17..31.
REQ-020 at_max / at_min SHALL update in the same cycle as counter_out (registered from next-state value, no extra lag).
REQ-021 Glitches shorter than DEBOUNCE_CYCLES SHALL produce no change.

Reset
REQ-022 While rst = 1 on a clock edge: counter_out = 0, at_min = 1, at_max = 0, both FSMs = STABLE_LO, debounce counters = 0, synchronizer flops = 0.
REQ-023 Reset mid-debounce SHALL discard the pending press; a button still held after reset release SHALL count once, after full REQ-014 latency measured from reset deassertion.
REQ-024 No output SHALL depend on reset asynchronously.

Structure
REQ-025 Shared package SHALL hold LEVEL_W = 5, LEVEL_MAX = 16, LEVEL_MIN = 0, and the debounce state enumeration.
REQ-026 SHALL instantiate one sub-module, button_debounce (synchronizer + FSM + counter + press pulse), twice.
REQ-027 Top level SHALL contain only the saturating counter and flag registers.

Verification (bench overrides DEBOUNCE_CYCLES = 4)
REQ-028 Reset, then btn_up held 20 cycles -> counter_out 0 -> 1 exactly 7 edges after first high sample; stays 1; at_min falls same cycle.
REQ-029 17 clean up presses (each 10 high / 10 low) -> counter_out reaches 16 after the 16th, at_max = 1, 17th press leaves 16.
REQ-030 From 0, one clean down press -> counter_out stays 0, at_min stays 1.
REQ-031 btn_up pulses of 3 cycles high, 1 low, repeated 10 times -> counter_out unchanged.
REQ-032 From 5, btn_up and btn_down rise on same edge, held 10 cycles -> counter_out stays 5.
REQ-033 From 8, rst asserted 1 cycle while btn_up in WAIT_HI, button held -> counter_out = 0 after reset, then 1 at 7 edges after reset release.

Source files
------------

// File: rtl/level_counter_pkg.sv
// Shared constants and types for the level counter and its button debouncers.
package level_counter_pkg;

  localparam int unsigned LEVEL_W = 5;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 5'd16;
  localparam logic [LEVEL_W-1:0] LEVEL_MIN = 5'd0;

  // Wide enough for any debounce length up to 2^20-1 cycles.
  localparam int unsigned DEB_CNT_W = 20;

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } deb_state_t;

endpackage

// File: rtl/level_counter_debounce.sv
// Synchronizes and debounces one raw push-button; emits a one-cycle
// registered pulse when a press is accepted. Releases produce no pulse.
module button_debounce
  import level_counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam logic [DEB_CNT_W-1:0] LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);

  logic                 sync_a;
  logic                 sync_b;
  deb_state_t           state;
  deb_state_t           state_nx;
  logic [DEB_CNT_W-1:0] cnt;
  logic [DEB_CNT_W-1:0] cnt_nx;
  logic                 press_nx;

  // Two-flop synchronizer, FSM state, stable-cycle counter and press pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      state  <= STABLE_LO;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
      state  <= state_nx;
      cnt    <= cnt_nx;
      press  <= press_nx;
    end
  end

  // Next-state logic. The edge that leaves a STABLE state already counts as
  // the first stable sample, so the wait lasts DEBOUNCE_CYCLES samples total.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    press_nx = 1'b0;
    case (state)
      STABLE_LO: begin
        if (sync_b) begin
          if (SINGLE) begin
            state_nx = STABLE_HI;
            press_nx = 1'b1;
            cnt_nx   = '0;
          end else begin
            state_nx = WAIT_HI;
            cnt_nx   = DEB_CNT_W'(1);
          end
        end
      end
      WAIT_HI: begin
        if (!sync_b) begin
          state_nx = STABLE_LO;
          cnt_nx   = '0;
        end else if (cnt >= LAST) begin
          state_nx = STABLE_HI;
          press_nx = 1'b1;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + DEB_CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!sync_b) begin
          if (SINGLE) begin
            state_nx = STABLE_LO;
            cnt_nx   = '0;
          end else begin
            state_nx = WAIT_LO;
            cnt_nx   = DEB_CNT_W'(1);
          end
        end
      end
      WAIT_LO: begin
        if (sync_b) begin
          state_nx = STABLE_HI;
          cnt_nx   = '0;
        end else if (cnt >= LAST) begin
          state_nx = STABLE_LO;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + DEB_CNT_W'(1);
        end
      end
      default: begin
        state_nx = STABLE_LO;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: rtl/level_counter.sv
// Saturating 0..16 level counter driven by debounced up/down buttons.
module level_counter
  import level_counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_up,
  input  logic               btn_down,
  output logic [LEVEL_W-1:0] counter_out,
  output logic               at_max,
  output logic               at_min
);

  logic               up_press;
  logic               down_press;
  logic [LEVEL_W-1:0] level_nx;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_up),
    .press (up_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_down),
    .press (down_press)
  );

  // Saturating step; simultaneous up and down presses cancel.
  always_comb begin
    level_nx = counter_out;
    if (up_press && !down_press && counter_out != LEVEL_MAX) begin
      level_nx = counter_out + LEVEL_W'(1);
    end else if (down_press && !up_press && counter_out != LEVEL_MIN) begin
      level_nx = counter_out - LEVEL_W'(1);
    end
  end

  // Level and flags registered together so the flags never lag the level.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter_out <= LEVEL_MIN;
      at_min      <= 1'b1;
      at_max      <= 1'b0;
    end else begin
      counter_out <= level_nx;
      at_min      <= (level_nx == LEVEL_MIN);
      at_max      <= (level_nx == LEVEL_MAX);
    end
  end

endmodule
